// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: instruction size, buffer entry layout and fetch FSM states.
package riscv_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned XLEN        = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order reservation FIFO: entries are allocated at request time and filled
// by memory responses in order, so the oldest unfilled entry trails the tail.
module fetch_buffer #(
    parameter int unsigned REG_BITS  = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic [REG_BITS-1:0]          alloc_pc,
    input  logic                         fill,
    input  logic [REG_BITS-1:0]          fill_instr,
    input  logic                         pop,
    output logic                         head_filled,
    output logic [REG_BITS-1:0]          head_pc,
    output logic [REG_BITS-1:0]          head_instr,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output logic [$clog2(BUF_DEPTH):0]   unfilled
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [REG_BITS-1:0]  pc_q    [BUF_DEPTH];
    logic [REG_BITS-1:0]  instr_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] filled_q;
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [PW-1:0]        fill_idx;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        unf_q;
    logic                 do_fill;

    // With every slot unfilled the low bits wrap to zero, landing on the head.
    assign fill_idx = tail_q - unf_q[PW-1:0];
    assign do_fill  = fill && (unf_q != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            unf_q    <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                pc_q[tail_q]     <= alloc_pc;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PW'(1);
            end
            if (do_fill) begin
                instr_q[fill_idx]  <= fill_instr;
                filled_q[fill_idx] <= 1'b1;
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
            unf_q   <= unf_q + CW'(alloc) - CW'(do_fill);
        end
    end

    assign head_filled = filled_q[head_q];
    assign head_pc     = pc_q[head_q];
    assign head_instr  = instr_q[head_q];
    assign count       = count_q;
    assign unfilled    = unf_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word fetches, buffers responses in order for decode,
// and flushes on redirect while draining stale in-flight responses.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned         REG_BITS     = 32,
    parameter int unsigned         BUF_DEPTH    = 2,
    parameter logic [REG_BITS-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] pc,
    output logic [REG_BITS-1:0] pcNext,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [REG_BITS-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [REG_BITS-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [REG_BITS-1:0] redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [REG_BITS-1:0] dec_instr,
    output logic [REG_BITS-1:0] dec_pc
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] drop_base;
    logic [CW-1:0] drop_new;
    logic [CW-1:0] count;
    logic [CW-1:0] unfilled;
    logic          head_filled;
    logic          req_fire;
    logic          pop;
    logic          fill;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req_addr  = {pc[REG_BITS-1:2], 2'b00};
    assign imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid
                            && (count < CW'(BUF_DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign dec_valid      = !rst && (state_q == FETCH) && head_filled && (count != '0);
    assign pop            = dec_valid && dec_ready && !redirect_valid;
    assign fill           = imem_rsp_valid && (state_q == FETCH) && !redirect_valid;

    // Only one of drop_q / unfilled is non-zero: the buffer is empty in DRAIN.
    assign drop_base = drop_q + unfilled;
    assign drop_new  = (imem_rsp_valid && (drop_base != '0)) ? drop_base - CW'(1) : drop_base;

    always_comb begin
        pcNext = pc;
        if (rst) begin
            pcNext = RESET_VECTOR;
        end else if (redirect_valid) begin
            pcNext = {redirect_pc[REG_BITS-1:2], 2'b00};
        end else if (req_fire) begin
            pcNext = pc + REG_BITS'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            drop_q  <= '0;
        end else if (redirect_valid) begin
            drop_q  <= drop_new;
            state_q <= (drop_new != '0) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                DRAIN: begin
                    if (imem_rsp_valid && (drop_q != '0)) begin
                        drop_q <= drop_q - CW'(1);
                        if (drop_q == CW'(1)) begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    fetch_buffer #(
        .REG_BITS (REG_BITS),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (imem_req_addr),
        .fill       (fill),
        .fill_instr (imem_rsp_data),
        .pop        (pop),
        .head_filled(head_filled),
        .head_pc    (dec_pc),
        .head_instr (dec_instr),
        .count      (count),
        .unfilled   (unfilled)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a queue-based reference model plus an
// in-order memory model drive the DUT; a separate monitor checks decode output.
module tb_instruction_fetch;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    instruction_fetch #(
        .REG_BITS    (32),
        .BUF_DEPTH   (DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pcNext        (pcNext),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decode stream: one entry per accepted fetch, visible from cycle vis.
    typedef struct { logic [31:0] pc; logic [31:0] instr; int vis; } exp_t;
    // Memory responses in flight; stale ones belong to fetches killed by a redirect.
    typedef struct { logic [31:0] data; int due; bit stale; } mem_t;

    exp_t        expq[$];
    mem_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] pc_model;

    bit          k_rst;
    bit          f_redir;
    logic [31:0] f_tgt;
    int          p_rdy, p_dec, p_redir, lat_lo, lat_hi;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
        return $urandom();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [31:0] pcn;
        logic [31:0] addr;
        bit          exp_req, exp_dec, fire, rsp;
        int          nstale, last, due, lat;
        mem_t        m;
        exp_t        e;

        @(negedge clk);
        cyc++;
        pc             = pc_model;
        rst            = k_rst;
        redirect_valid = f_redir || ($urandom_range(99) < p_redir);
        redirect_pc    = f_redir ? f_tgt : rand_target();
        f_redir        = 1'b0;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        dec_ready      = ($urandom_range(99) < p_dec);
        rsp            = !k_rst && (pend.size() != 0) && (pend[0].due == cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? pend[0].data : $urandom();
        #1;

        nstale = 0;
        foreach (pend[i]) if (pend[i].stale) nstale++;
        exp_req = !k_rst && (nstale == 0) && !redirect_valid && (expq.size() < DEPTH);
        exp_dec = !k_rst && (nstale == 0) && (expq.size() != 0) && (expq[0].vis <= cyc);
        fire    = exp_req && imem_req_ready;
        addr    = {pc_model[31:2], 2'b00};

        if (k_rst)               pcn = RV;
        else if (redirect_valid) pcn = {redirect_pc[31:2], 2'b00};
        else if (fire)           pcn = pc_model + 32'd4;
        else                     pcn = pc_model;

        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        check("dec_valid", 32'(dec_valid), 32'(exp_dec));
        check("pcNext", pcNext, pcn);
        if (exp_req) check("req_addr", imem_req_addr, addr);

        if (k_rst) begin
            expq.delete();
            pend.delete();
        end else begin
            if (rsp) begin
                if (!pend[0].stale)
                    assert (expq.size() != 0) else $error("protocol: response with no outstanding fetch");
                void'(pend.pop_front());
            end
            if (redirect_valid) begin
                expq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
            end else if (fire) begin
                lat    = int'($urandom_range(lat_hi, lat_lo));
                last   = (pend.size() != 0) ? pend[$].due : cyc;
                due    = (cyc + lat > last) ? cyc + lat : last + 1;
                m.data = memword(addr); m.due = due; m.stale = 1'b0;
                pend.push_back(m);
                e.pc = addr; e.instr = memword(addr); e.vis = due + 1;
                expq.push_back(e);
            end
        end
        pc_model = pcn;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every accepted decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst === 1'b0 && !redirect_valid && dec_valid && dec_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec_unexpected cycle %0d: got pc %h expected no instruction", cyc, dec_pc);
            end else begin
                e = expq.pop_front();
                check("dec_pc", dec_pc, e.pc);
                check("dec_instr", dec_instr, e.instr);
            end
        end
    end

    initial begin
        rst = 1'b1; pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
        pc_model = RV; k_rst = 1'b1; f_redir = 1'b0; f_tgt = '0;
        p_rdy = 100; p_dec = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;

        run(2);
        k_rst = 1'b0;
        run(20);

        p_dec = 0;   run(6);
        p_dec = 100; run(10);

        p_rdy = 0;   run(3);
        p_rdy = 100; run(5);

        lat_lo = 3; lat_hi = 3;
        run(6);
        f_redir = 1'b1; f_tgt = 32'h0000_0103;
        run(15);

        lat_lo = 1; lat_hi = 1;
        run(4);
        f_redir = 1'b1; f_tgt = 32'h0000_0200;
        run(8);

        f_redir = 1'b1; f_tgt = 32'hFFFF_FFFC;
        run(8);

        p_dec = 0; run(5);
        k_rst = 1'b1; run(1);
        k_rst = 1'b0; p_dec = 100; run(8);

        for (int blk = 0; blk < 60; blk++) begin
            p_rdy   = int'($urandom_range(100, 50));
            p_dec   = int'($urandom_range(100, 30));
            p_redir = int'($urandom_range(8));
            lat_lo  = 1;
            lat_hi  = int'($urandom_range(5, 1));
            for (int i = 0; i < 50; i++) begin
                k_rst = ($urandom_range(999) < 3);
                step();
            end
        end

        k_rst = 1'b0; p_redir = 0; p_rdy = 0; p_dec = 100;
        for (int i = 0; i < 100 && (expq.size() != 0 || pend.size() != 0); i++) step();
        checks++;
        if (expq.size() != 0 || pend.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", expq.size() + pend.size());
        end
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
